mem_port_arbiter: RTL

//  Shares the single main-memory port between the instruction-cache and data-cache controllers.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_wait_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory port arbiter: FSM states, requester IDs
// and the memory direction encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter for the memory port arbiter. Loads a count, then
// decrements toward zero without ever wrapping.
module mem_wait_counter #(
  parameter int unsigned CTR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec_en,
  output logic             zero,
  output logic             last
);

  logic [CTR_W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap to all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == CTR_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the main-memory port between the I-cache and
// D-cache controllers; issues one memory strobe and one ready pulse per grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CTR_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_strobe,
  input  logic i_rw,
  output logic i_ready,
  input  logic d_strobe,
  input  logic d_rw,
  output logic d_ready,
  output logic m_strobe,
  output logic m_rw,
  output logic m_sel,
  output logic busy
);

  generate
    if ((WAIT_CYCLES >> CTR_W) != 0) begin : g_bad_wait_cycles
      $error("mem_port_arbiter: WAIT_CYCLES does not fit in CTR_W bits");
    end
  endgenerate

  localparam logic [CTR_W-1:0] LOAD_VAL = CTR_W'(WAIT_CYCLES);
  localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);

  state_t  state;
  state_t  next_state;
  req_id_t last_grant;
  req_id_t sel_q;
  req_id_t grant_id;
  logic    grant_valid;
  logic    cnt_load;
  logic    cnt_dec;
  logic    cnt_zero;
  logic    cnt_last;

  mem_wait_counter #(
    .CTR_W(CTR_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // On a tie the side that did not win last time gets the port
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_id    = REQ_I;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (i_strobe && d_strobe) begin
          grant_valid = 1'b1;
          grant_id    = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (i_strobe) begin
          grant_valid = 1'b1;
          grant_id    = REQ_I;
        end else if (d_strobe) begin
          grant_valid = 1'b1;
          grant_id    = REQ_D;
        end
        if (grant_valid) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        cnt_load   = 1'b1;
        next_state = NO_WAIT ? DONE : WAIT;
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Select and direction are frozen at grant so a dropped strobe cannot disturb them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= REQ_I;
      m_rw       <= 1'b0;
      last_grant <= REQ_D;
    end else begin
      if (grant_valid) begin
        sel_q <= grant_id;
        m_rw  <= (grant_id == REQ_D) ? d_rw : i_rw;
      end
      if (state == DONE) begin
        last_grant <= sel_q;
      end
    end
  end

  assign m_sel    = sel_q;
  assign m_strobe = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign i_ready  = (state == DONE) && (sel_q == REQ_I);
  assign d_ready  = (state == DONE) && (sel_q == REQ_D);

endmodule
